// File: rtl/dallanma_pkg.sv
// Shared definitions for the branch predictor: RISC-V opcode constants, the
// 2-bit saturating counter encoding with its reset value, and the B-/J-type
// immediate extraction helpers.
package dallanma_pkg;

  localparam logic [6:0] OpBtipi = 7'b1100011;  // conditional branches
  localparam logic [6:0] OpJal   = 7'b1101111;  // unconditional direct jump

  // Bit[1] of the counter is the predicted direction.
  typedef enum logic [1:0] {
    SayacGucluAlinmaz = 2'b00,
    SayacZayifAlinmaz = 2'b01,
    SayacZayifAlinir  = 2'b10,
    SayacGucluAlinir  = 2'b11
  } sayac_e;

  localparam sayac_e SayacReset = SayacZayifAlinmaz;

  // Sign-extended B-type immediate.
  function automatic logic [31:0] b_imm(input logic [31:0] buyruk);
    return {{20{buyruk[31]}}, buyruk[7], buyruk[30:25], buyruk[11:8], 1'b0};
  endfunction

  // Sign-extended J-type immediate.
  function automatic logic [31:0] j_imm(input logic [31:0] buyruk);
    return {{12{buyruk[31]}}, buyruk[19:12], buyruk[20], buyruk[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/dallanma_ongorucu_if.sv
// Fetch/execute/prediction bundle of the branch predictor.
//   master : pipeline side, drives getir_* and yurut_*, receives sonuc_*
//   slave  : predictor side
interface dallanma_ongorucu_if;

  logic [31:0] getir_ps;
  logic [31:0] getir_buyruk;
  logic        getir_gecerli;
  logic [31:0] yurut_ps;
  logic [31:0] yurut_buyruk;
  logic        yurut_dallan;
  logic [31:0] yurut_dallan_ps;
  logic        yurut_gecerli;
  logic        sonuc_dallan;
  logic [31:0] sonuc_dallan_ps;

  modport master (
    output getir_ps, getir_buyruk, getir_gecerli,
    output yurut_ps, yurut_buyruk, yurut_dallan, yurut_dallan_ps, yurut_gecerli,
    input  sonuc_dallan, sonuc_dallan_ps
  );

  modport slave (
    input  getir_ps, getir_buyruk, getir_gecerli,
    input  yurut_ps, yurut_buyruk, yurut_dallan, yurut_dallan_ps, yurut_gecerli,
    output sonuc_dallan, sonuc_dallan_ps
  );

endinterface

// File: rtl/ongoru_tablosu.sv
// Pattern history table of 2-bit saturating counters.
//   clk, rst_n     : clock, asynchronous active-low reset (all entries -> 01)
//   okuma_idx_i    : combinational read index (fetch)
//   okuma_sayac_o  : counter at okuma_idx_i, pre-update value
//   yazma_en_i     : perform read-modify-write on this edge
//   yazma_idx_i    : entry to update
//   yazma_dallan_i : resolved direction, 1 increments, 0 decrements
module ongoru_tablosu
  import dallanma_pkg::*;
#(
  parameter int unsigned Derinlik = 64,
  localparam int unsigned IdxW = $clog2(Derinlik)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] okuma_idx_i,
  output sayac_e          okuma_sayac_o,
  input  logic            yazma_en_i,
  input  logic [IdxW-1:0] yazma_idx_i,
  input  logic            yazma_dallan_i
);

  sayac_e sayac_q [Derinlik];
  sayac_e eski;
  sayac_e yeni;

  // Read from the registered array, so a same-cycle update is not visible yet.
  assign okuma_sayac_o = sayac_q[okuma_idx_i];

  always_comb begin
    eski = sayac_q[yazma_idx_i];
    yeni = eski;
    if (yazma_dallan_i) begin
      if (eski != SayacGucluAlinir) yeni = sayac_e'(eski + 2'd1);
    end else begin
      if (eski != SayacGucluAlinmaz) yeni = sayac_e'(eski - 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Derinlik); i++) sayac_q[i] <= SayacReset;
    end else if (yazma_en_i) begin
      sayac_q[yazma_idx_i] <= yeni;
    end
  end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Bimodal/gshare branch direction predictor with 0-cycle fetch prediction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : fetch inputs, execute resolution inputs, prediction outputs
// Parameters: PHT_DERINLIK (table entries, power of two), GECMIS_BIT (global
// history width), MOD (0 = bimodal, 1 = gshare).
module dallanma_ongorucu
  import dallanma_pkg::*;
#(
  parameter int unsigned PHT_DERINLIK = 64,
  parameter int unsigned GECMIS_BIT   = 6,
  parameter int unsigned MOD          = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  dallanma_ongorucu_if.slave  bus_io
);

  localparam int unsigned IdxW = $clog2(PHT_DERINLIK);

  logic [GECMIS_BIT-1:0] ghr_q, ghr_d;
  logic [IdxW-1:0]       ghr_idx;
  logic [IdxW-1:0]       getir_idx;
  logic [IdxW-1:0]       yurut_idx;
  logic                  getir_btipi, getir_jal;
  logic                  guncelle;
  sayac_e                getir_sayac;

  // History is zero-extended or truncated to the index width.
  assign ghr_idx = IdxW'(ghr_q);

  always_comb begin
    getir_idx = bus_io.getir_ps[IdxW+1:2];
    yurut_idx = bus_io.yurut_ps[IdxW+1:2];
    if (MOD == 1) begin
      getir_idx = getir_idx ^ ghr_idx;
      yurut_idx = yurut_idx ^ ghr_idx;
    end
  end

  assign getir_btipi = (bus_io.getir_buyruk[6:0] == OpBtipi);
  assign getir_jal   = (bus_io.getir_buyruk[6:0] == OpJal);
  assign guncelle    = bus_io.yurut_gecerli && (bus_io.yurut_buyruk[6:0] == OpBtipi);

  always_comb begin
    bus_io.sonuc_dallan    = bus_io.getir_gecerli &&
                             (getir_jal || (getir_btipi && getir_sayac[1]));
    bus_io.sonuc_dallan_ps = bus_io.getir_ps + 32'd4;
    if (bus_io.sonuc_dallan) begin
      bus_io.sonuc_dallan_ps = bus_io.getir_ps +
                               (getir_jal ? j_imm(bus_io.getir_buyruk)
                                          : b_imm(bus_io.getir_buyruk));
    end
  end

  // Truncating the concatenation also covers the 1-bit history case.
  always_comb begin
    ghr_d = ghr_q;
    if (guncelle) ghr_d = GECMIS_BIT'({ghr_q, bus_io.yurut_dallan});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  ongoru_tablosu #(
    .Derinlik (PHT_DERINLIK)
  ) u_tablo (
    .clk            (clk),
    .rst_n          (rst_n),
    .okuma_idx_i    (getir_idx),
    .okuma_sayac_o  (getir_sayac),
    .yazma_en_i     (guncelle),
    .yazma_idx_i    (yurut_idx),
    .yazma_dallan_i (bus_io.yurut_dallan)
  );

  // Resolved target is carried for a later generation; unused here.
  logic unused_ok;
  assign unused_ok = ^{bus_io.yurut_dallan_ps, bus_io.getir_ps, bus_io.yurut_ps,
                       bus_io.yurut_buyruk, ghr_q, getir_sayac[0]};

endmodule

// File: tb/tb_dallanma_ongorucu.sv
module tb_dallanma_ongorucu;

  localparam logic [31:0] Beq  = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] Jal  = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] Jalr = 32'h0000_8067;
  localparam logic [31:0] Add  = 32'h0000_0033;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dallanma_ongorucu_if if0 ();
  dallanma_ongorucu_if if1 ();

  dallanma_ongorucu #(.PHT_DERINLIK(64), .GECMIS_BIT(6), .MOD(0)) u_bimodal (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if0)
  );

  dallanma_ongorucu #(.PHT_DERINLIK(64), .GECMIS_BIT(6), .MOD(1)) u_gshare (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic getir_kur(input int m, input logic [31:0] ps, input logic [31:0] buyruk,
                           input logic gecerli);
    if (m == 0) begin
      if0.getir_ps = ps; if0.getir_buyruk = buyruk; if0.getir_gecerli = gecerli;
    end else begin
      if1.getir_ps = ps; if1.getir_buyruk = buyruk; if1.getir_gecerli = gecerli;
    end
  endtask

  task automatic sonuc_kontrol(input int m, input string tag, input logic exp_d,
                               input logic [31:0] exp_ps);
    if (m == 0) begin
      kontrol({tag, "_d"}, {31'b0, if0.sonuc_dallan}, {31'b0, exp_d});
      kontrol({tag, "_ps"}, if0.sonuc_dallan_ps, exp_ps);
    end else begin
      kontrol({tag, "_d"}, {31'b0, if1.sonuc_dallan}, {31'b0, exp_d});
      kontrol({tag, "_ps"}, if1.sonuc_dallan_ps, exp_ps);
    end
  endtask

  task automatic bak(input int m, input string tag, input logic [31:0] ps,
                     input logic [31:0] buyruk, input logic gecerli, input logic exp_d,
                     input logic [31:0] exp_ps);
    @(negedge clk);
    getir_kur(m, ps, buyruk, gecerli);
    #1;
    sonuc_kontrol(m, tag, exp_d, exp_ps);
  endtask

  task automatic yurut(input int m, input logic [31:0] ps, input logic [31:0] buyruk,
                       input logic dallan, input logic gecerli);
    if (m == 0) begin
      if0.yurut_ps = ps; if0.yurut_buyruk = buyruk; if0.yurut_dallan = dallan;
      if0.yurut_dallan_ps = ps + 32'd16; if0.yurut_gecerli = gecerli;
    end else begin
      if1.yurut_ps = ps; if1.yurut_buyruk = buyruk; if1.yurut_dallan = dallan;
      if1.yurut_dallan_ps = ps + 32'd16; if1.yurut_gecerli = gecerli;
    end
    @(posedge clk);
    #1;
    if0.yurut_gecerli = 1'b0;
    if1.yurut_gecerli = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if0.getir_ps = '0; if0.getir_buyruk = '0; if0.getir_gecerli = 1'b0;
    if0.yurut_ps = '0; if0.yurut_buyruk = '0; if0.yurut_dallan = 1'b0;
    if0.yurut_dallan_ps = '0; if0.yurut_gecerli = 1'b0;
    if1.getir_ps = '0; if1.getir_buyruk = '0; if1.getir_gecerli = 1'b0;
    if1.yurut_ps = '0; if1.yurut_buyruk = '0; if1.yurut_dallan = 1'b0;
    if1.yurut_dallan_ps = '0; if1.yurut_gecerli = 1'b0;

    // Outputs while held in reset
    bak(0, "rst_beq0", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(1, "rst_beq1", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(0, "rst_jal", 32'h200, Jal, 1'b1, 1'b1, 32'h1F8);
    rst_n = 1'b1;

    // Decode and target generation
    bak(0, "beq0", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(1, "beq1", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(0, "jal", 32'h200, Jal, 1'b1, 1'b1, 32'h1F8);
    bak(0, "jal_inv", 32'h200, Jal, 1'b0, 1'b0, 32'h204);
    bak(0, "jalr", 32'h300, Jalr, 1'b1, 1'b0, 32'h304);
    bak(0, "jal_wrap", 32'h4, Jal, 1'b1, 1'b1, 32'hFFFF_FFFC);
    bak(1, "beq_inv", 32'h100, Beq, 1'b0, 1'b0, 32'h104);

    // Non-branch and invalid execute slots leave state alone
    yurut(0, 32'h100, Add, 1'b1, 1'b1);
    yurut(0, 32'h100, Beq, 1'b1, 1'b0);
    yurut(1, 32'h100, Add, 1'b1, 1'b1);
    yurut(1, 32'h100, Beq, 1'b1, 1'b0);
    bak(0, "nonbr0", 32'h100, Beq, 1'b1, 1'b0, 32'h104);

    // gshare: entry 0 -> 10, GHR = 1
    yurut(1, 32'h100, Beq, 1'b1, 1'b1);
    bak(1, "gs_100", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(1, "gs_104", 32'h104, Beq, 1'b1, 1'b1, 32'h114);
    // idx 1^1=0: entry 0 -> 01, GHR = 2; then idx 2^2=0: entry 0 -> 10, GHR = 5
    yurut(1, 32'h104, Beq, 1'b0, 1'b1);
    bak(1, "gs_108", 32'h108, Beq, 1'b1, 1'b0, 32'h10C);
    yurut(1, 32'h108, Beq, 1'b1, 1'b1);
    bak(1, "gs_114", 32'h114, Beq, 1'b1, 1'b1, 32'h124);
    bak(1, "gs_100b", 32'h100, Beq, 1'b1, 1'b0, 32'h104);

    // Bimodal training and saturation on entry 0
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    bak(0, "bm_t1", 32'h100, Beq, 1'b1, 1'b1, 32'h110);
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    bak(0, "bm_t2", 32'h100, Beq, 1'b1, 1'b1, 32'h110);
    for (int i = 0; i < 4; i++) yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    yurut(0, 32'h100, Beq, 1'b0, 1'b1);
    bak(0, "bm_nt1", 32'h100, Beq, 1'b1, 1'b1, 32'h110);
    yurut(0, 32'h100, Beq, 1'b0, 1'b1);
    bak(0, "bm_nt2", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    bak(0, "bm_other", 32'h104, Beq, 1'b1, 1'b0, 32'h108);
    for (int i = 0; i < 3; i++) yurut(0, 32'h100, Beq, 1'b0, 1'b1);
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    bak(0, "bm_sat0", 32'h100, Beq, 1'b1, 1'b0, 32'h104);

    // Asynchronous reset mid-cycle after training to 11
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    bak(0, "pre_rst", 32'h100, Beq, 1'b1, 1'b1, 32'h110);
    #1 rst_n = 1'b0;
    #1 sonuc_kontrol(0, "rst_async", 1'b0, 32'h104);

    // Update while reset is low is lost; first edge after release is accepted
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bak(0, "rst_lost", 32'h100, Beq, 1'b1, 1'b0, 32'h104);
    yurut(0, 32'h100, Beq, 1'b1, 1'b1);
    bak(0, "rst_first", 32'h100, Beq, 1'b1, 1'b1, 32'h110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dallanma_ongorucu.md
DALLANMA_ONGORUCU -- requirements
Module: dallanma_ongorucu

Interface
REQ-001 Parameter PHT_DERINLIK, 64: number of pattern-table entries; SHALL be a power of two, 4..4096.
REQ-002 Parameter GECMIS_BIT, 6: global-history register width, 1..12.
REQ-003 Parameter MOD, 1: index mode; 0 = bimodal, 1 = gshare.
REQ-004 clk  in  1: single clock; all state updates occur on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 getir_ps  in  32: PC of the instruction in fetch.
REQ-007 getir_buyruk  in  32: instruction word in fetch.
REQ-008 getir_gecerli  in  1: fetch slot valid.
REQ-009 yurut_ps  in  32: PC of the instruction in execute.
REQ-010 yurut_buyruk  in  32: instruction word in execute.
REQ-011 yurut_dallan  in  1: resolved direction in execute (1 = taken).
REQ-012 yurut_dallan_ps  in  32: resolved target; accepted but unused in this generation.
REQ-013 yurut_gecerli  in  1: execute slot valid.
REQ-014 sonuc_dallan  out  1: predicted taken for the fetch instruction.
REQ-015 sonuc_dallan_ps  out  32: predicted next PC.

Function
REQ-016 IDX = log2(PHT_DERINLIK); the base index SHALL be ps[IDX+1:2].
REQ-017 MOD=0: index = base. MOD=1: index = base XOR GHR, with GHR zero-extended or truncated to IDX bits.
REQ-018 Each entry SHALL be a 2-bit saturating counter; 00/01 predict not taken, 10/11 predict taken.
REQ-019 Decode: B-type is opcode 1100011, JAL is 1101111; all other opcodes are non-branch, JALR included.
REQ-020 Prediction SHALL be combinational (0-cycle latency) from getir_* and the registered table/GHR.
REQ-021 sonuc_dallan SHALL be 1 when getir_gecerli=1 and either the instruction is JAL, or it is B-type and the indexed counter bit[1]=1; otherwise 0.
REQ-022 When sonuc_dallan=1, sonuc_dallan_ps SHALL be getir_ps plus the sign-extended J- or B-immediate; otherwise getir_ps+4. Arithmetic is modulo 2^32.
REQ-023 Update occurs on the clock edge where yurut_gecerli=1 and yurut_buyruk is B-type; every other execute instruction changes no state.
REQ-024 Update counter: increment on yurut_dallan=1 and decrement on 0; saturate at 11 and at 00.
REQ-025 The update index SHALL use yurut_ps and the GHR value before the edge.
REQ-026 On update, GHR = {GHR[GECMIS_BIT-2:0], yurut_dallan} (shift left, LSB in); on GECMIS_BIT=1, GHR = yurut_dallan.
REQ-027 Updated state is visible to fetch in the next cycle.
REQ-028 When fetch and update address the same entry in one cycle, fetch SHALL see the pre-update value.
REQ-029 GHR is updated non-speculatively (execute only); no fetch-side history or recovery.

Reset
REQ-030 rst_n=0 SHALL immediately set all counters to 01 and GHR to 0, independent of clk.
REQ-031 While rst_n=0, outputs follow REQ-021/022 using reset state: B-type is not taken and JAL is taken.
REQ-032 An update coincident with reset assertion SHALL be lost.
REQ-033 The first update is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package dallanma_pkg SHALL hold the opcode constants, the counter encodings and reset value (01), and the B- and J-immediate extraction functions.
REQ-035 Sub-module ongoru_tablosu SHALL hold the counter array, with one combinational read port, one synchronous read-modify-write port and async reset; the GHR and decode stay in the top module.

Verification
REQ-036 After reset, fetch beq at 0x100 with imm +16 -> sonuc_dallan=0, sonuc_dallan_ps=0x104.
REQ-037 Fetch JAL at 0x200 with imm -8 -> sonuc_dallan=1, sonuc_dallan_ps=0x1F8; fetch with getir_gecerli=0 -> sonuc_dallan=0.
REQ-038 MOD=0: two taken updates of beq at 0x100 -> fetch predicts taken, ps=0x110. After six taken updates, one not-taken update still predicts taken; two not-taken updates predict not taken.
REQ-039 MOD=1, PHT 64: one taken update of beq at 0x100 (entry 0 becomes 10, GHR=1) -> fetch beq at 0x100 (index 1) not taken; fetch beq at 0x104 (index 0) taken.
REQ-040 Execute add (0110011) with yurut_dallan=1, and a B-type with yurut_gecerli=0 -> table and GHR unchanged.
REQ-041 Train 0x100 to 11, then pulse rst_n low mid-cycle -> fetch at 0x100 not taken before the next clk edge.
